// File: rtl/mips_fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_fetch_queue_pkg : constants shared by fetch and mips_decode     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_fetch_queue_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
  localparam int          ENTRY_W      = 64;

  localparam logic [5:0]  OP_SPECIAL   = 6'h00;
  localparam logic [5:0]  OP_J         = 6'h02;
  localparam logic [5:0]  OP_BEQ       = 6'h04;
  localparam logic [5:0]  OP_LW        = 6'h23;
  localparam logic [5:0]  OP_SW        = 6'h2B;
  localparam logic [5:0]  OP0_ADD      = 6'h20;
  localparam logic [5:0]  OP0_SUB      = 6'h22;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_fetch_queue_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : DEPTH x {pc,inst} queue with wrap-bit pointers, clear   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_fifo
  import mips_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic [AW:0]        count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q,  count_d;
  logic               w_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign w_rd    = rd_en & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (w_rd) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, w_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_fetch_queue : PC owner, credit-based imem issue, decode feed    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mips_fetch_queue
  import mips_fetch_queue_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_VEC,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q,   req_pc_d;
  logic               inflight_q, inflight_d;
  logic               kill_q,     kill_d;

  logic               w_empty;
  logic [AW:0]        w_count;
  logic [ENTRY_W-1:0] w_head;
  logic               w_deq;
  logic               w_enq;
  logic [AW+1:0]      w_committed;
  logic               w_credit;

  assign inst_valid  = ~w_empty;
  assign w_deq       = inst_valid & inst_ready & ~redirect;
  // deq can only fire with a non-empty queue, so the subtraction never underflows
  assign w_committed = {1'b0, w_count} + {{(AW+1){1'b0}}, inflight_q}
                     - {{(AW+1){1'b0}}, w_deq};
  assign w_credit    = (w_committed < (AW+2)'(DEPTH));
  // the reset term keeps the strobe low while the queue is held in reset
  assign imem_req    = reset & ~redirect & w_credit;
  assign imem_addr   = fetch_pc_q;
  assign w_enq       = inflight_q & ~kill_q & ~redirect;

  assign inst_pc     = w_head[63:32];
  assign inst        = w_head[31:0];
  assign opcode      = inst[31:26];
  assign funct       = inst[5:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    kill_d     = redirect & inflight_q;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_RESET;
      req_pc_q   <= PC_RESET;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .clear   (redirect),
    .wr_en   (w_enq),
    .wr_data ({req_pc_q, imem_rdata}),
    .rd_en   (w_deq),
    .rd_data (w_head),
    .empty   (w_empty),
    .count   (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_fetch_queue : directed self-checking bench for fetch queue   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mips_fetch_queue;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  int n_checks = 0;
  int n_errors = 0;

  mips_fetch_queue #(
    .PC_RESET (32'h0040_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .opcode      (opcode),
    .funct       (funct)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0050_0000: return 32'h0085_1020;
      32'h0050_0004: return 32'h0085_1022;
      32'h0050_0008: return 32'h8C82_0004;
      default:       return a;
    endcase
  endfunction

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // an enqueue into a full queue without a matching dequeue would be an overflow
  always @(negedge clock) begin
    if (reset === 1'b1)
      check_eq("no_overflow",
               {31'b0, dut.w_enq & ~dut.w_deq & (dut.w_count == DEPTH[1:0])}, 32'h0);
  end

  initial begin
    reset = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc(); #2;
    check_eq("rst_req",   {31'b0, imem_req},   32'h0);
    check_eq("rst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("rst_inst",  inst,                32'h0);
    check_eq("rst_pc",    inst_pc,             32'h0);
    check_eq("rst_addr",  imem_addr,           32'h0040_0000);

    // streaming from reset release
    cyc(); reset = 1'b1; inst_ready = 1'b1; #2;
    check_eq("s0_req",   {31'b0, imem_req},   32'h1);
    check_eq("s0_addr",  imem_addr,           32'h0040_0000);
    check_eq("s0_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); #2;
    check_eq("s1_addr",  imem_addr,           32'h0040_0004);
    check_eq("s1_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); #2;
    check_eq("s2_valid", {31'b0, inst_valid}, 32'h1);
    check_eq("s2_inst",  inst,                32'h0040_0000);
    check_eq("s2_pc",    inst_pc,             32'h0040_0000);
    check_eq("s2_addr",  imem_addr,           32'h0040_0008);
    cyc(); #2;
    check_eq("s3_inst",  inst,                32'h0040_0004);
    check_eq("s3_pc",    inst_pc,             32'h0040_0004);
    check_eq("s3_addr",  imem_addr,           32'h0040_000C);

    // reset mid-stream with a request in flight
    cyc(); reset = 1'b0; #2;
    check_eq("mr_valid",  {31'b0, inst_valid}, 32'h0);
    check_eq("mr_inst",   inst,                32'h0);
    check_eq("mr_pc",     inst_pc,             32'h0);
    check_eq("mr_opcode", {26'b0, opcode},     32'h0);
    check_eq("mr_funct",  {26'b0, funct},      32'h0);
    check_eq("mr_req",    {31'b0, imem_req},   32'h0);
    cyc();

    // backpressure: exactly DEPTH requests, then hold
    cyc(); reset = 1'b1; inst_ready = 1'b0; #2;
    check_eq("bp0_req",  {31'b0, imem_req},   32'h1);
    check_eq("bp0_addr", imem_addr,           32'h0040_0000);
    check_eq("bp0_valid",{31'b0, inst_valid}, 32'h0);
    cyc(); #2;
    check_eq("bp1_req",  {31'b0, imem_req},   32'h1);
    check_eq("bp1_addr", imem_addr,           32'h0040_0004);
    cyc(); #2;
    check_eq("bp2_req",  {31'b0, imem_req},   32'h0);
    check_eq("bp2_inst", inst,                32'h0040_0000);
    cyc(); #2;
    check_eq("bp3_req",  {31'b0, imem_req},   32'h0);
    check_eq("bp3_inst", inst,                32'h0040_0000);
    cyc(); inst_ready = 1'b1; #2;
    check_eq("bp4_req",  {31'b0, imem_req},   32'h1);
    check_eq("bp4_addr", imem_addr,           32'h0040_0008);
    check_eq("bp4_inst", inst,                32'h0040_0000);
    cyc(); #2;
    check_eq("bp5_inst", inst,                32'h0040_0004);
    check_eq("bp5_addr", imem_addr,           32'h0040_000C);

    // redirect with a queued head and a response in flight
    cyc(); redirect = 1'b1; redirect_pc = 32'h0040_0103; #2;
    check_eq("rd0_req",  {31'b0, imem_req},   32'h0);
    check_eq("rd0_inst", inst,                32'h0040_0008);
    cyc(); redirect = 1'b0; #2;
    check_eq("rd1_valid",{31'b0, inst_valid}, 32'h0);
    check_eq("rd1_addr", imem_addr,           32'h0040_0100);
    check_eq("rd1_req",  {31'b0, imem_req},   32'h1);
    cyc(); #2;
    check_eq("rd2_valid",{31'b0, inst_valid}, 32'h0);
    check_eq("rd2_addr", imem_addr,           32'h0040_0104);
    cyc(); #2;
    check_eq("rd3_inst", inst,                32'h0040_0100);
    check_eq("rd3_pc",   inst_pc,             32'h0040_0100);

    // decode field split
    cyc(); redirect = 1'b1; redirect_pc = 32'h0050_0000; #2;
    check_eq("dc0_req",  {31'b0, imem_req},   32'h0);
    cyc(); redirect = 1'b0; #2;
    check_eq("dc1_addr", imem_addr,           32'h0050_0000);
    cyc(); #2;
    cyc(); #2;
    check_eq("add_inst", inst,                32'h0085_1020);
    check_eq("add_op",   {26'b0, opcode},     32'h0);
    check_eq("add_fn",   {26'b0, funct},      32'h20);
    check_eq("add_pc",   inst_pc,             32'h0050_0000);
    cyc(); #2;
    check_eq("sub_fn",   {26'b0, funct},      32'h22);
    cyc(); #2;
    check_eq("lw_op",    {26'b0, opcode},     32'h23);
    check_eq("lw_fn",    {26'b0, funct},      32'h04);

    // back-to-back redirects, then wrap at the top of the address space
    cyc(); redirect = 1'b1; redirect_pc = 32'h0060_0000; #2;
    check_eq("bb0_req",  {31'b0, imem_req},   32'h0);
    cyc(); redirect_pc = 32'hFFFF_FFF8; #2;
    check_eq("bb1_req",  {31'b0, imem_req},   32'h0);
    check_eq("bb1_valid",{31'b0, inst_valid}, 32'h0);
    cyc(); redirect = 1'b0; #2;
    check_eq("wr0_addr", imem_addr,           32'hFFFF_FFF8);
    check_eq("wr0_req",  {31'b0, imem_req},   32'h1);
    cyc(); #2;
    check_eq("wr1_addr", imem_addr,           32'hFFFF_FFFC);
    cyc(); #2;
    check_eq("wr2_addr", imem_addr,           32'h0);
    check_eq("wr2_pc",   inst_pc,             32'hFFFF_FFF8);
    cyc(); #2;
    check_eq("wr3_pc",   inst_pc,             32'hFFFF_FFFC);
    cyc(); #2;
    check_eq("wr4_valid",{31'b0, inst_valid}, 32'h1);
    check_eq("wr4_pc",   inst_pc,             32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
